// File: rtl/hamming_decoder_pkg.sv
// Shared types and constants for the byte-serial SECDED Hamming(16,11) decoder.
// Bit layout: p0 at bit 0, p1/p2/p4/p8 at their index, data in the remaining positions.
package hamming_decoder_pkg;

  typedef enum logic [1:0] {
    kOK   = 2'b00,
    kCORR = 2'b01,
    kDED  = 2'b10
  } status_e;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    CALC,
    OUT
  } state_e;

  // Lowest codeword position of each contiguous data run: d0, d3:d1, d10:d4
  localparam int unsigned D0_POS = 3;
  localparam int unsigned D1_POS = 5;
  localparam int unsigned D4_POS = 9;

  // Syndrome bit k covers every position whose index has bit k set (bit 0 never included)
  localparam logic [15:0] S1_MASK = 16'hAAAA;
  localparam logic [15:0] S2_MASK = 16'hCCCC;
  localparam logic [15:0] S4_MASK = 16'hF0F0;
  localparam logic [15:0] S8_MASK = 16'hFF00;

  function automatic logic [10:0] extract_data(input logic [15:0] cw);
    return {cw[15:D4_POS], cw[7:D1_POS], cw[D0_POS]};
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational SECDED check: syndrome, single-error correction, double-error detection
// and data extraction for one 16-bit codeword.
module hamming_syndrome
  import hamming_decoder_pkg::*;
(
  input  logic [15:0] i_cw,
  output logic [3:0]  o_syn,
  output logic [10:0] o_data,
  output logic [1:0]  o_status
);

  logic        w_par;
  logic [15:0] w_fixed;

  always_comb begin
    o_syn   = {^(i_cw & S8_MASK), ^(i_cw & S4_MASK), ^(i_cw & S2_MASK), ^(i_cw & S1_MASK)};
    w_par   = ^i_cw;
    w_fixed = i_cw;
    o_status = kOK;
    if (w_par) begin
      o_status = kCORR;
      // Zero syndrome with odd parity means p0 itself flipped; data untouched
      if (o_syn != 4'd0) begin
        w_fixed[o_syn] = ~i_cw[o_syn];
      end
    end else if (o_syn != 4'd0) begin
      o_status = kDED;
    end
    o_data = extract_data(w_fixed);
  end

endmodule

// File: rtl/hamming_decoder.sv
// Byte-serial SECDED decoder: low byte then high byte in, 11-bit message plus status out.
// Define HAMMING_STATS_EN to add saturating corr_cnt/ded_cnt statistics ports.
module hamming_decoder
  import hamming_decoder_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [10:0] out_data,
  output logic [1:0]  out_status,
  output logic [3:0]  out_syn
`ifdef HAMMING_STATS_EN
  ,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] ded_cnt
`endif
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("hamming_decoder: CNT_W must be at least 1");
  end

  state_e      r_state;
  state_e      w_state_d;
  logic [15:0] r_cw;
  logic [10:0] r_data;
  status_e     r_status;
  logic [3:0]  r_syn;

  logic [3:0]  w_syn;
  logic [10:0] w_data;
  logic [1:0]  w_status;
  logic        w_in_fire;
  logic        w_out_fire;

  hamming_syndrome u_syndrome (
    .i_cw     (r_cw),
    .o_syn    (w_syn),
    .o_data   (w_data),
    .o_status (w_status)
  );

  always_comb begin
    w_state_d = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_d = LO;
      end
      LO: begin
        in_ready = 1'b1;
        if (in_valid) w_state_d = CALC;
      end
      CALC: w_state_d = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_state_d = IDLE;
      end
      default: w_state_d = IDLE;
    endcase
  end

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cw     <= '0;
      r_data   <= '0;
      r_status <= kOK;
      r_syn    <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_in_fire) begin
        if (r_state == IDLE) r_cw[7:0]  <= in_byte;
        else                 r_cw[15:8] <= in_byte;
      end
      if (r_state == CALC) begin
        r_data   <= w_data;
        r_status <= status_e'(w_status);
        r_syn    <= w_syn;
      end
    end
  end

  assign out_data   = r_data;
  assign out_status = r_status;
  assign out_syn    = r_syn;

`ifdef HAMMING_STATS_EN
  logic [CNT_W-1:0] r_corr_cnt;
  logic [CNT_W-1:0] r_ded_cnt;

  // Counters saturate at all-ones rather than wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_corr_cnt <= '0;
      r_ded_cnt  <= '0;
    end else if (w_out_fire) begin
      if (r_status == kCORR && r_corr_cnt != '1) r_corr_cnt <= r_corr_cnt + 1'b1;
      if (r_status == kDED && r_ded_cnt != '1)   r_ded_cnt  <= r_ded_cnt + 1'b1;
    end
  end

  assign corr_cnt = r_corr_cnt;
  assign ded_cnt  = r_ded_cnt;
`else
  logic w_unused_fire;
  assign w_unused_fire = w_out_fire;
`endif

endmodule
